// File: rtl/periph_rx_arbiter.sv
//------------------------------------------------------------------------------
// periph_rx_arbiter
//
// Merges the RX FIFO streams of NUM_PERIPHS peripherals into one packet stream
// toward the USB transmit path. Peripherals that are not empty and report
// ready are eligible. Eligible peripherals that are almost full are served
// before all others. Within the active class the grant rotates round-robin
// from rr_ptr. A grant may take up to MAX_BURST packets back-to-back before
// the pointer moves on. Packets pass through unmodified.
//
// Each packet goes through four states:
//   ARB -> RD (read strobe) -> CAP (FIFO dout valid, captured) -> OUT (held
//   until usb_ready).
//
// Ports:
//   clk                    system clock
//   rst                    synchronous active-high reset
//   periph_rx_data         packed FIFO dout, peripheral i at [i*PACKET_WIDTH +: PACKET_WIDTH]
//   periph_rx_read         one-hot read strobe to the granted FIFO
//   periph_rx_empty        FIFO empty flags
//   periph_rx_almost_full  FIFO prog-full flags (urgency)
//   periph_ready           peripheral ready flags
//   usb_data               packet toward USB
//   usb_valid              usb_data valid
//   usb_ready              downstream accepts usb_data this cycle
//   grant_id               index of the currently granted peripheral
//   busy                   high whenever the arbiter is not in ARB
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module periph_rx_arbiter #(
  parameter int NUM_PERIPHS  = 8,
  parameter int PACKET_WIDTH = 32,
  parameter int MAX_BURST    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PERIPHS*PACKET_WIDTH-1:0] periph_rx_data,
  output logic [NUM_PERIPHS-1:0]              periph_rx_read,
  input  logic [NUM_PERIPHS-1:0]              periph_rx_empty,
  input  logic [NUM_PERIPHS-1:0]              periph_rx_almost_full,
  input  logic [NUM_PERIPHS-1:0]              periph_ready,
  output logic [PACKET_WIDTH-1:0]             usb_data,
  output logic                                usb_valid,
  input  logic                                usb_ready,
  output logic [$clog2(NUM_PERIPHS)-1:0]      grant_id,
  output logic                                busy
);

  localparam int ID_W  = $clog2(NUM_PERIPHS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ARB = 2'd0,
    RD  = 2'd1,
    CAP = 2'd2,
    OUT = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_ptr_nxt;
  logic [CNT_W-1:0]   burst_cnt;
  logic [CNT_W-1:0]   burst_cnt_nxt;
  logic [CNT_W-1:0]   burst_inc;
  logic [ID_W-1:0]    grant_nxt;
  logic [ID_W-1:0]    grant_inc;
  logic               usb_valid_nxt;
  logic               usb_data_ld;

  logic [NUM_PERIPHS-1:0] eligible;
  logic [NUM_PERIPHS-1:0] urgent;
  logic [NUM_PERIPHS-1:0] pool;
  logic [NUM_PERIPHS-1:0] others_urgent;
  logic                   pick_found;
  logic [ID_W-1:0]        pick_id;

  assign eligible      = ~periph_rx_empty & periph_ready;
  assign urgent        = eligible & periph_rx_almost_full;
  assign pool          = (urgent != '0) ? urgent : eligible;
  assign others_urgent = urgent & ~(NUM_PERIPHS'(1) << grant_id);
  assign burst_inc     = burst_cnt + CNT_W'(1);
  assign grant_inc     = (grant_id == ID_W'(NUM_PERIPHS - 1)) ? '0 : grant_id + ID_W'(1);
  assign busy          = (state != ARB);

  // Round-robin pick: first pool bit at rr_ptr, rr_ptr+1, ... with wrap.
  // NUM_PERIPHS need not be a power of two, so the wrap is explicit.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < NUM_PERIPHS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PERIPHS) idx = idx - NUM_PERIPHS;
      if (!pick_found && pool[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    burst_cnt_nxt  = burst_cnt;
    grant_nxt      = grant_id;
    usb_valid_nxt  = usb_valid;
    usb_data_ld    = 1'b0;
    periph_rx_read = '0;
    case (state)
      // ARB: choose the next peripheral
      ARB: begin
        if (pick_found) begin
          grant_nxt     = pick_id;
          burst_cnt_nxt = '0;
          state_nxt     = RD;
        end
      end
      // RD: strobe the FIFO only if it is still readable
      RD: begin
        if (eligible[grant_id]) begin
          periph_rx_read[grant_id] = 1'b1;
          state_nxt                = CAP;
        end else begin
          rr_ptr_nxt = grant_inc;
          state_nxt  = ARB;
        end
      end
      // CAP: FIFO dout is valid now (1-cycle read latency)
      CAP: begin
        usb_data_ld   = 1'b1;
        usb_valid_nxt = 1'b1;
        state_nxt     = OUT;
      end
      // OUT: hold the packet until accepted, then continue or release
      OUT: begin
        if (usb_ready) begin
          usb_valid_nxt = 1'b0;
          burst_cnt_nxt = burst_inc;
          if ((burst_inc < CNT_W'(MAX_BURST)) && eligible[grant_id] &&
              (others_urgent == '0)) begin
            state_nxt = RD;
          end else begin
            rr_ptr_nxt = grant_inc;
            state_nxt  = ARB;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      grant_id  <= '0;
      usb_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
      grant_id  <= grant_nxt;
      usb_valid <= usb_valid_nxt;
    end
  end

  // A reset drops any packet captured but not yet accepted, so the data
  // register is cleared along with the control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      usb_data <= '0;
    end else if (usb_data_ld) begin
      usb_data <= periph_rx_data[int'(grant_id)*PACKET_WIDTH +: PACKET_WIDTH];
    end
  end

endmodule

// File: tb/tb_periph_rx_arbiter.sv
`timescale 1ns/1ps
module tb_periph_rx_arbiter;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int MB = 2;

  logic             clk;
  logic             rst;
  logic [N*W-1:0]   periph_rx_data;
  logic [N-1:0]     periph_rx_read;
  logic [N-1:0]     periph_rx_empty;
  logic [N-1:0]     periph_rx_almost_full;
  logic [N-1:0]     periph_ready;
  logic [W-1:0]     usb_data;
  logic             usb_valid;
  logic             usb_ready;
  logic [2:0]       grant_id;
  logic             busy;

  periph_rx_arbiter #(
    .NUM_PERIPHS (N),
    .PACKET_WIDTH(W),
    .MAX_BURST   (MB)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .periph_rx_data       (periph_rx_data),
    .periph_rx_read       (periph_rx_read),
    .periph_rx_empty      (periph_rx_empty),
    .periph_rx_almost_full(periph_rx_almost_full),
    .periph_ready         (periph_ready),
    .usb_data             (usb_data),
    .usb_valid            (usb_valid),
    .usb_ready            (usb_ready),
    .grant_id             (grant_id),
    .busy                 (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  logic [W-1:0] fifo_q [N][$];
  logic [W-1:0] got [$];
  logic [W-1:0] exp_q [$];
  int           reads_cnt [N];
  logic [N-1:0] rd_neg = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO models: 1-cycle read latency, dout updated just after the edge
  // on which the strobe was seen.
  initial begin
    periph_rx_empty = '1;
    periph_rx_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rd_neg[i] === 1'b1) begin
          check("read_nonempty_fifo", 32'(fifo_q[i].size() > 0), 32'd1);
          if (fifo_q[i].size() > 0) periph_rx_data[i*W +: W] = fifo_q[i].pop_front();
        end
        periph_rx_empty[i] = (fifo_q[i].size() == 0);
      end
    end
  end

  // Reference model: packet-level view advanced once per clock.
  // m_ph: 0 choosing, 1 issuing read, 2 data arriving, 3 presenting packet.
  int           m_ph = 0;
  int           m_ptr = 0;
  int           m_cnt = 0;
  int           m_g = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [N-1:0] mel, mur, mpl;

  initial begin
    forever begin
      @(posedge clk);
      mel = ~periph_rx_empty & periph_ready;
      mur = mel & periph_rx_almost_full;
      mpl = (mur != 0) ? mur : mel;
      if (rst) begin
        m_ph = 0; m_ptr = 0; m_cnt = 0; m_g = 0; m_valid = 1'b0; m_data = '0;
      end else if (m_ph == 0) begin
        for (int k = 0; k < N; k++) begin
          if (mpl[(m_ptr + k) % N]) begin
            m_g = (m_ptr + k) % N; m_cnt = 0; m_ph = 1;
            break;
          end
        end
      end else if (m_ph == 1) begin
        if (mel[m_g]) m_ph = 2;
        else begin m_ptr = (m_g + 1) % N; m_ph = 0; end
      end else if (m_ph == 2) begin
        m_data = periph_rx_data[m_g*W +: W];
        m_valid = 1'b1;
        m_ph = 3;
      end else if (usb_ready) begin
        int others;
        others = 0;
        for (int i = 0; i < N; i++) if (mur[i] && i != m_g) others++;
        m_valid = 1'b0;
        m_cnt++;
        if (m_cnt < MB && mel[m_g] && others == 0) m_ph = 1;
        else begin m_ptr = (m_g + 1) % N; m_ph = 0; end
      end
    end
  end

  // Compare and log at the falling edge.
  initial begin
    logic [N-1:0] cel;
    logic [N-1:0] exp_rd;
    for (int i = 0; i < N; i++) reads_cnt[i] = 0;
    forever begin
      @(negedge clk);
      rd_neg = periph_rx_read;
      for (int i = 0; i < N; i++) if (periph_rx_read[i] === 1'b1) reads_cnt[i]++;
      if (usb_valid === 1'b1 && usb_ready === 1'b1) got.push_back(usb_data);
      if (chk_en) begin
        cel = ~periph_rx_empty & periph_ready;
        exp_rd = '0;
        if (m_ph == 1 && cel[m_g]) exp_rd[m_g] = 1'b1;
        check("usb_valid", 32'(usb_valid), 32'(m_valid));
        check("usb_data", usb_data, m_data);
        check("grant_id", 32'(grant_id), 32'(m_g));
        check("busy", 32'(busy), 32'(m_ph != 0));
        check("periph_rx_read", 32'(periph_rx_read), 32'(exp_rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit fifos_empty();
    for (int i = 0; i < N; i++) if (fifo_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      n++;
      if (usb_valid === 1'b1) return;
    end
    check("wait_valid", 32'(usb_valid), 32'd1);
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (fifos_empty() && busy === 1'b0 && usb_valid === 1'b0) quiet++;
      else quiet = 0;
      if (quiet >= 3) return;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_got(input string name);
    check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check(name, got[i], exp_q[i]);
  endtask

  initial begin
    int n;
    int base;
    bit found;
    rst = 1'b1;
    usb_ready = 1'b0;
    periph_ready = '1;
    periph_rx_almost_full = '0;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_usb_valid", 32'(usb_valid), 32'd0);
    check("rst_usb_data", usb_data, 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_read", 32'(periph_rx_read), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Single packet with a stalled consumer.
    got.delete();
    base = reads_cnt[2];
    fifo_q[2].push_back(32'h4000_00AB);
    wait_valid(n);
    check("t1_latency", 32'(n), 32'd4);
    repeat (5) begin
      tick();
      check("t1_hold_data", usb_data, 32'h4000_00AB);
      check("t1_hold_valid", 32'(usb_valid), 32'd1);
    end
    usb_ready = 1'b1;
    drain();
    check("t1_reads", 32'(reads_cnt[2] - base), 32'd1);
    exp_q = '{32'h4000_00AB};
    check_got("t1_out");

    // Pointer now at 3: FIFO3 beats FIFO2.
    got.delete();
    fifo_q[2].push_back(32'h2222_0002);
    fifo_q[3].push_back(32'h3333_0003);
    drain();
    exp_q = '{32'h3333_0003, 32'h2222_0002};
    check_got("t1_ptr3");

    // Round-robin with bursts of two.
    got.delete();
    for (int i = 0; i < 3; i++) begin
      fifo_q[0].push_back(32'hA0 + 32'(i));
      fifo_q[1].push_back(32'hB0 + 32'(i));
    end
    drain();
    exp_q = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hA2, 32'hB2};
    check_got("t2_rr");

    // Move pointer to 0 via FIFO7, then urgency.
    fifo_q[7].push_back(32'h77);
    drain();
    got.delete();
    usb_ready = 1'b0;
    fifo_q[1].push_back(32'h11);
    fifo_q[3].push_back(32'h31);
    fifo_q[5].push_back(32'h51);
    fifo_q[5].push_back(32'h52);
    fifo_q[5].push_back(32'h53);
    periph_rx_almost_full[5] = 1'b1;
    wait_valid(n);
    check("t3_first_grant", 32'(grant_id), 32'd5);
    check("t3_first_data", usb_data, 32'h51);
    periph_rx_almost_full[3] = 1'b1;
    usb_ready = 1'b1;
    drain();
    exp_q = '{32'h51, 32'h31, 32'h52, 32'h53, 32'h11};
    check_got("t3_urgent");
    periph_rx_almost_full = '0;

    // Not-ready peripheral is never read.
    got.delete();
    base = reads_cnt[4];
    periph_ready[4] = 1'b0;
    fifo_q[4].push_back(32'h44);
    repeat (20) tick();
    check("t4_no_read", 32'(reads_cnt[4] - base), 32'd0);
    check("t4_no_out", 32'(got.size()), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);
    periph_ready[4] = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (periph_rx_read[4] === 1'b1) begin found = 1'b1; break; end
    end
    check("t4_served_in_4", 32'(found), 32'd1);
    drain();
    exp_q = '{32'h44};
    check_got("t4_out");

    // Wrap: pointer to 7 via FIFO6, then 7 before 0.
    fifo_q[6].push_back(32'h66);
    drain();
    got.delete();
    fifo_q[7].push_back(32'h70);
    fifo_q[0].push_back(32'h01);
    drain();
    exp_q = '{32'h70, 32'h01};
    check_got("t5_wrap");
    got.delete();
    fifo_q[0].push_back(32'h02);
    fifo_q[1].push_back(32'h12);
    drain();
    exp_q = '{32'h12, 32'h02};
    check_got("t5_ptr1");

    // Reset while a packet is stalled in OUT.
    got.delete();
    usb_ready = 1'b0;
    fifo_q[5].push_back(32'hC1);
    fifo_q[5].push_back(32'hC2);
    wait_valid(n);
    check("t6_grant", 32'(grant_id), 32'd5);
    rst = 1'b1;
    fifo_q[0].push_back(32'hD0);
    tick();
    check("t6_valid", 32'(usb_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_grant_rst", 32'(grant_id), 32'd0);
    check("t6_data_rst", usb_data, 32'd0);
    rst = 1'b0;
    usb_ready = 1'b1;
    drain();
    exp_q = '{32'hD0, 32'hC2};
    check_got("t6_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/periph_rx_arbiter.md
Name: periph_rx_arbiter

Overview:
- Sits directly downstream of the peripheral blocks' RX FIFOs and upstream of the USB transmit path.
- Merges the per-peripheral RX streams into one packet stream toward the USB bus.
- Arbitration is round-robin with bounded bursts. Peripherals asserting almost-full are served first.
- Packets pass through unmodified; the top periph_address_width bits already carry the source address.

Parameters:
NUM_PERIPHS, 8, number of peripheral RX FIFOs arbitrated
PACKET_WIDTH, 32 (usb_packet_width), width of one packet
MAX_BURST, 4, max consecutive packets taken from one peripheral before the pointer advances (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
periph_rx_data  input  NUM_PERIPHS*PACKET_WIDTH  packed RX FIFO dout; peripheral i at [i*PACKET_WIDTH +: PACKET_WIDTH]
periph_rx_read  output  NUM_PERIPHS  one-hot read strobe to RX FIFO i
periph_rx_empty  input  NUM_PERIPHS  RX FIFO empty flags
periph_rx_almost_full  input  NUM_PERIPHS  RX FIFO prog-full flags
periph_ready  input  NUM_PERIPHS  peripheral post-reset ready flags
usb_data  output  PACKET_WIDTH  packet toward USB
usb_valid  output  1  usb_data valid
usb_ready  input  1  downstream accepts usb_data this cycle
grant_id  output  $clog2(NUM_PERIPHS)  index of peripheral currently granted
busy  output  1  high whenever state != ARB

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset state: state=ARB, rr_ptr=0, burst_cnt=0. Outputs: usb_valid=0, usb_data=0, grant_id=0, periph_rx_read=0, busy=0.
- Reset mid-operation: next cycle is reset state. Any packet already read but not yet accepted is dropped.
- Eligibility: eligible[i] = ~periph_rx_empty[i] & periph_ready[i]. urgent = eligible & periph_rx_almost_full.
- Arbitration pool: pool = urgent if urgent is nonzero, else eligible.
- ARB state: pick the first set bit of pool scanning rr_ptr, rr_ptr+1, ..., wrapping NUM_PERIPHS-1 -> 0. If found, grant_id <= pick, burst_cnt <= 0, go to RD. Else remain in ARB.
- RD state (1 cycle):
  - periph_rx_read[grant_id]=1 combinationally, only if periph_rx_empty[grant_id]=0 and periph_ready[grant_id]=1; go to CAP.
  - Otherwise no strobe; rr_ptr <= grant_id+1 mod N; go to ARB.
  - All other read bits are always 0. An empty FIFO is never read.
- CAP state (1 cycle):
  - The FIFO has 1-cycle read latency, so dout is valid in this cycle.
  - On this edge: usb_data <= slice[grant_id], usb_valid <= 1; go to OUT.
- OUT state:
  - usb_data and usb_valid are held stable until usb_ready=1.
  - On the usb_ready edge: usb_valid <= 0, burst_cnt <= burst_cnt+1.
  - Continue the burst (go to RD) if all hold: burst_cnt+1 < MAX_BURST, eligible[grant_id], and urgent has no bit other than grant_id.
  - Otherwise: rr_ptr <= grant_id+1 mod N (N-1 wraps to 0); go to ARB.
- Throughput: 1 packet per 3 cycles within a burst when usb_ready is held high. Worst case from ARB: 4 cycles (ARB, RD, CAP, OUT).
- periph_ready deasserting or almost_full changing during CAP/OUT does not abort the in-flight packet.
- grant_id holds its value outside ARB and keeps the last grant while in ARB.

Test Plan:
- Single packet: FIFO 2 holds 0x4000_00AB, usb_ready=0 for 5 cycles then 1 -> exactly one periph_rx_read[2] pulse; usb_valid high from the 4th cycle after empty drops; usb_data=0x4000_00AB stable throughout the stall; one transfer; then ARB with rr_ptr=3.
- Round-robin with burst limit: MAX_BURST=2, FIFO0 holds A0..A2, FIFO1 holds B0..B2, usb_ready=1 -> output order A0 A1 B0 B1 A2 B2.
- Urgency: FIFO1 non-empty, FIFO5 non-empty with almost_full=1, rr_ptr=0 -> FIFO5 served first. Mid-burst on FIFO5, FIFO3 raises almost_full -> burst ends after the current packet and FIFO3 is served next.
- Not-ready skip: FIFO4 non-empty with periph_ready[4]=0 -> no read of FIFO4 ever. Raising ready -> FIFO4 served within 4 cycles.
- Wrap: rr_ptr=7, FIFO7 and FIFO0 each with one packet -> order 7 then 0; rr_ptr=1 afterwards.
- Reset mid-OUT: rst for 1 cycle while usb_valid=1 -> next cycle usb_valid=0, busy=0, rr_ptr=0; remaining FIFO contents are served normally afterwards.
